// File: rtl/muldiv_unit_pkg.sv
// Shared MDU header: op codes, FSM encodings and small op-decode helpers.
package muldiv_unit_pkg;
  localparam int MDU_OP_LENGTH = 3;

  localparam logic [MDU_OP_LENGTH-1:0] MDU_OP_MULT  = 3'd0;
  localparam logic [MDU_OP_LENGTH-1:0] MDU_OP_MULTU = 3'd1;
  localparam logic [MDU_OP_LENGTH-1:0] MDU_OP_DIV   = 3'd2;
  localparam logic [MDU_OP_LENGTH-1:0] MDU_OP_DIVU  = 3'd3;
  localparam logic [MDU_OP_LENGTH-1:0] MDU_OP_MTHI  = 3'd4;
  localparam logic [MDU_OP_LENGTH-1:0] MDU_OP_MTLO  = 3'd5;

  localparam logic [1:0] MDU_S_IDLE = 2'd0;
  localparam logic [1:0] MDU_S_CALC = 2'd1;
  localparam logic [1:0] MDU_S_FIX  = 2'd2;

  // Codes 0..3 are the iterative mul/div group; bit 1 selects divide, bit 0 unsigned.
  function automatic logic mdu_is_iter(input logic [MDU_OP_LENGTH-1:0] op);
    return op[2] == 1'b0;
  endfunction

  function automatic logic mdu_is_signed(input logic [MDU_OP_LENGTH-1:0] op);
    return (op == MDU_OP_MULT) || (op == MDU_OP_DIV);
  endfunction
endpackage

// File: rtl/muldiv_unit_signfix.sv
// Conditional two's-complement negate, used for operand abs and result sign correction.
module mdu_signfix #(
  parameter int WIDTH = 32
) (
  input  logic             i_neg,
  input  logic [WIDTH-1:0] i_val,
  output logic [WIDTH-1:0] o_val
);
  assign o_val = i_neg ? (~i_val + WIDTH'(1)) : i_val;
endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with HI/LO: shift-add multiply, restoring divide,
// one bit per cycle, magnitude datapath with sign correction in a final FIX cycle.
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_start,
  input  logic [MDU_OP_LENGTH-1:0] i_op,
  input  logic [WIDTH-1:0]         i_src_a,
  input  logic [WIDTH-1:0]         i_src_b,
  input  logic                     i_flush,
  output logic                     o_busy,
  output logic                     o_done,
  output logic                     o_div_by_zero,
  output logic [WIDTH-1:0]         o_hi,
  output logic [WIDTH-1:0]         o_lo
);
  logic [1:0]         r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [2*WIDTH-1:0] r_acc;    // mul: {partial, multiplier}; div: low half = dividend -> quotient
  logic [WIDTH-1:0]   r_rem;
  logic [WIDTH-1:0]   r_opnd;   // multiplicand or divisor magnitude
  logic               r_is_div, r_dbz_op, r_sign_lo, r_sign_hi;
  logic [WIDTH-1:0]   r_hi, r_lo;
  logic               r_done, r_dbz;

  logic [WIDTH-1:0] w_abs_a, w_abs_b, w_fix_lo, w_fix_hi, w_res_hi, w_hi_out;
  logic [WIDTH:0]   w_mul_sum, w_shift, w_diff;
  logic             w_signed, w_b_zero, w_ge;

  assign w_signed = mdu_is_signed(i_op);
  assign w_b_zero = (i_src_b == '0);

  mdu_signfix #(.WIDTH(WIDTH)) u_abs_a (.i_neg(w_signed & i_src_a[WIDTH-1]), .i_val(i_src_a), .o_val(w_abs_a));
  mdu_signfix #(.WIDTH(WIDTH)) u_abs_b (.i_neg(w_signed & i_src_b[WIDTH-1]), .i_val(i_src_b), .o_val(w_abs_b));

  assign w_mul_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
  assign w_shift   = {r_rem, r_acc[WIDTH-1]};
  assign w_diff    = w_shift - {1'b0, r_opnd};
  assign w_ge      = ~w_diff[WIDTH];

  assign w_res_hi = r_is_div ? r_rem : r_acc[2*WIDTH-1:WIDTH];

  mdu_signfix #(.WIDTH(WIDTH)) u_fix_lo (.i_neg(r_sign_lo & ~r_dbz_op), .i_val(r_acc[WIDTH-1:0]), .o_val(w_fix_lo));
  mdu_signfix #(.WIDTH(WIDTH)) u_fix_hi (.i_neg(r_sign_hi & ~r_dbz_op), .i_val(w_res_hi), .o_val(w_fix_hi));

  // 2*WIDTH negate: the +1 only carries into the high half when the low half is zero.
  assign w_hi_out = (!r_is_div && r_sign_lo && (r_acc[WIDTH-1:0] != '0)) ? ~w_res_hi : w_fix_hi;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state   <= MDU_S_IDLE;
      r_cnt     <= '0;
      r_acc     <= '0;
      r_rem     <= '0;
      r_opnd    <= '0;
      r_is_div  <= 1'b0;
      r_dbz_op  <= 1'b0;
      r_sign_lo <= 1'b0;
      r_sign_hi <= 1'b0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_done    <= 1'b0;
      r_dbz     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_state != MDU_S_IDLE && i_flush) begin
        r_state <= MDU_S_IDLE;
      end else begin
        case (r_state)
          MDU_S_IDLE: begin
            if (i_start && mdu_is_iter(i_op)) begin
              r_state   <= MDU_S_CALC;
              r_cnt     <= CNT_W'(WIDTH);
              r_is_div  <= i_op[1];
              r_dbz_op  <= i_op[1] & w_b_zero;
              r_sign_lo <= w_signed & (i_src_a[WIDTH-1] ^ i_src_b[WIDTH-1]);
              r_sign_hi <= w_signed & (i_op[1] ? i_src_a[WIDTH-1]
                                               : (i_src_a[WIDTH-1] ^ i_src_b[WIDTH-1]));
              // A zero divisor keeps raw src_a so it can be returned untouched in HI.
              r_acc     <= {{WIDTH{1'b0}}, i_op[1] ? (w_b_zero ? i_src_a : w_abs_a) : w_abs_b};
              r_opnd    <= i_op[1] ? w_abs_b : w_abs_a;
              r_rem     <= '0;
              r_dbz     <= 1'b0;
            end else if (i_start && i_op == MDU_OP_MTHI) begin
              r_hi <= i_src_a;
            end else if (i_start && i_op == MDU_OP_MTLO) begin
              r_lo <= i_src_a;
            end
          end
          MDU_S_CALC: begin
            if (!r_dbz_op) begin
              if (r_is_div) begin
                r_rem            <= w_ge ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
                r_acc[WIDTH-1:0] <= {r_acc[WIDTH-2:0], w_ge};
              end else begin
                r_acc <= {w_mul_sum, r_acc[WIDTH-1:1]};
              end
            end
            r_cnt <= r_cnt - CNT_W'(1);
            if (r_cnt == CNT_W'(1)) r_state <= MDU_S_FIX;
          end
          MDU_S_FIX: begin
            r_hi    <= r_dbz_op ? r_acc[WIDTH-1:0] : w_hi_out;
            r_lo    <= r_dbz_op ? '1 : w_fix_lo;
            r_dbz   <= r_dbz_op;
            r_done  <= 1'b1;
            r_state <= MDU_S_IDLE;
          end
          default: r_state <= MDU_S_IDLE;
        endcase
      end
    end
  end

  assign o_busy        = (r_state != MDU_S_IDLE);
  assign o_done        = r_done;
  assign o_div_by_zero = r_dbz;
  assign o_hi          = r_hi;
  assign o_lo          = r_lo;
endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed cases plus random mul/div against a 64-bit arithmetic model.
module tb_muldiv_unit;
  import muldiv_unit_pkg::*;
  localparam int W = 32;

  logic         clk = 1'b0, rst_n = 1'b0, start = 1'b0, flush = 1'b0;
  logic [2:0]   op = '0;
  logic [W-1:0] a = '0, b = '0;
  logic         busy, done, dbz;
  logic [W-1:0] hi, lo;

  muldiv_unit #(.WIDTH(W)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_op(op), .i_src_a(a), .i_src_b(b),
    .i_flush(flush), .o_busy(busy), .o_done(done), .o_div_by_zero(dbz), .o_hi(hi), .o_lo(lo)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;
  logic [W-1:0] m_hi = '0, m_lo = '0;
  logic         m_dbz = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Architectural result straight from integer arithmetic.
  task automatic model(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    longint          sx, sy, sq, sr;
    longint unsigned ux, uy, uq, ur;
    logic [63:0]     r64;
    sx = longint'($signed(x)); sy = longint'($signed(y));
    ux = {32'b0, x};           uy = {32'b0, y};
    m_dbz = 1'b0;
    case (o)
      MDU_OP_MULT:  begin r64 = sx * sy; m_hi = r64[63:32]; m_lo = r64[31:0]; end
      MDU_OP_MULTU: begin r64 = ux * uy; m_hi = r64[63:32]; m_lo = r64[31:0]; end
      MDU_OP_DIV, MDU_OP_DIVU: begin
        if (y == '0) begin
          m_lo = '1; m_hi = x; m_dbz = 1'b1;
        end else if (o == MDU_OP_DIV) begin
          sq = sx / sy; sr = sx % sy; m_lo = sq[31:0]; m_hi = sr[31:0];
        end else begin
          uq = ux / uy; ur = ux % uy; m_lo = uq[31:0]; m_hi = ur[31:0];
        end
      end
      default: ;
    endcase
  endtask

  task automatic chk_regs(input string tag);
    chk({tag, "_hi"}, hi, m_hi);
    chk({tag, "_lo"}, lo, m_lo);
    chk({tag, "_dbz"}, dbz, m_dbz);
  endtask

  // Issue one mul/div and follow it to completion; optionally try an MTHI while busy.
  task automatic do_op(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y, input bit inj);
    int lat, nbusy;
    @(negedge clk); start = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1; start = 1'b0;
    lat = 0; nbusy = 0;
    while (!done && lat < 3*W) begin
      if (busy) nbusy++;
      if (inj && lat == 5) begin start = 1'b1; op = MDU_OP_MTHI; a = 32'hBAD0BAD0; end
      else if (inj && lat == 6) start = 1'b0;
      @(posedge clk); #1; lat++;
    end
    model(o, x, y);
    chk("latency", lat, W + 1);
    chk("busy_cycles", nbusy, W + 1);
    chk("busy_at_done", busy, 1'b0);
    chk_regs("result");
  endtask

  initial begin
    logic [2:0]   ro;
    logic [W-1:0] rx, ry;
    bit           saw_done;

    repeat (3) @(posedge clk); #1;
    chk("rst_busy", busy, 1'b0); chk("rst_done", done, 1'b0);
    chk_regs("rst");
    rst_n = 1'b1;

    do_op(MDU_OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
    chk("multu_max_hi", hi, 32'hFFFFFFFE); chk("multu_max_lo", lo, 32'h00000001);
    do_op(MDU_OP_MULT, 32'hFFFFFFFD, 32'd5, 0);
    chk("mult_neg_lo", lo, 32'hFFFFFFF1);
    do_op(MDU_OP_MULT, 32'h80000000, 32'h80000000, 0);
    chk("mult_min_hi", hi, 32'h40000000);
    do_op(MDU_OP_DIV, 32'hFFFFFFF9, 32'd2, 0);
    chk("div_neg_lo", lo, 32'hFFFFFFFD); chk("div_neg_hi", hi, 32'hFFFFFFFF);
    do_op(MDU_OP_DIVU, 32'd100, 32'd7, 0);
    chk("divu_lo", lo, 32'd14);
    do_op(MDU_OP_DIV, 32'h80000000, 32'hFFFFFFFF, 0);
    chk("div_ovf_lo", lo, 32'h80000000); chk("div_ovf_hi", hi, 32'h0);
    do_op(MDU_OP_DIVU, 32'h1234, 32'h0, 0);
    chk("dbz_flag", dbz, 1'b1); chk("dbz_hi", hi, 32'h1234);
    do_op(MDU_OP_MULTU, 32'd2, 32'd3, 1);
    chk("mthi_busy_ignored", hi, 32'h0); chk("dbz_cleared", dbz, 1'b0);

    // MTLO then MTHI in consecutive idle cycles
    @(negedge clk); start = 1'b1; op = MDU_OP_MTLO; a = 32'hDEAD;
    @(posedge clk); #1;
    chk("mtlo_lo", lo, 32'hDEAD);
    op = MDU_OP_MTHI; a = 32'hBEEF;
    @(posedge clk); #1; start = 1'b0;
    m_lo = 32'hDEAD; m_hi = 32'hBEEF;
    chk_regs("mt");
    chk("mt_done", done, 1'b0); chk("mt_busy", busy, 1'b0);

    // Unused op code does nothing
    @(negedge clk); start = 1'b1; op = 3'd6; a = $urandom; b = $urandom;
    @(posedge clk); #1; start = 1'b0;
    chk("badop_busy", busy, 1'b0);
    @(posedge clk); #1;
    chk("badop_done", done, 1'b0);
    chk_regs("badop");

    // Flush during cycle 10 of a MULT
    @(negedge clk); start = 1'b1; op = MDU_OP_MULT; a = 32'h12345678; b = 32'hFFFF0001;
    @(posedge clk); #1; start = 1'b0; m_dbz = 1'b0;
    repeat (9) @(posedge clk); #1; flush = 1'b1;
    @(posedge clk); #1; flush = 1'b0;
    chk("flush_busy", busy, 1'b0); chk("flush_done", done, 1'b0);
    chk_regs("flush");
    saw_done = 0;
    for (int i = 0; i < W + 3; i++) begin
      @(posedge clk); #1;
      if (done) saw_done = 1;
    end
    chk("flush_no_done", saw_done, 1'b0);
    do_op(MDU_OP_MULTU, 32'd7, 32'd9, 0);

    // Reset mid-DIV, then a start right after
    @(negedge clk); start = 1'b1; op = MDU_OP_DIV; a = 32'h7FFF0000; b = 32'd3;
    @(posedge clk); #1; start = 1'b0;
    repeat (10) @(posedge clk); #1; rst_n = 1'b0;
    @(posedge clk); #1; rst_n = 1'b1;
    m_hi = '0; m_lo = '0; m_dbz = 1'b0;
    chk("midrst_busy", busy, 1'b0); chk("midrst_done", done, 1'b0);
    chk_regs("midrst");
    do_op(MDU_OP_DIVU, 32'd1000, 32'd3, 0);

    for (int n = 0; n < 40; n++) begin
      ro = 3'($urandom_range(0, 3));
      rx = ($urandom_range(0, 7) == 0) ? 32'h80000000 : 32'($urandom);
      case ($urandom_range(0, 7))
        0:       ry = '0;
        1:       ry = 32'($urandom_range(1, 15));
        2:       ry = 32'hFFFFFFFF;
        default: ry = 32'($urandom);
      endcase
      do_op(ro, rx, ry, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
